// File: rtl/fsm_table_engine_pkg.sv
// Shared types and helpers for the table-driven FSM engine.
// Optional step counter is enabled by defining FSM_STEP_CNT_EN.
package fsm_tbl_pkg;

  localparam int DEF_SW = 4;
  localparam int DEF_IW = 4;
  localparam int DEF_K  = 6;

  typedef struct packed {
    logic              en;
    logic [DEF_IW-1:0] val;
    logic [DEF_IW-1:0] mask;
    logic [DEF_SW-1:0] next;
  } rule_t;

  localparam int RULE_W = $bits(rule_t);

  // A single rule still needs a one-bit index so the cfg port never collapses.
  function automatic int rule_idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/fsm_table_engine_if.sv
// Symbol, rule-configuration and observation signals of the table-driven FSM.
interface fsm_tbl_if
  import fsm_tbl_pkg::*;
#(
  parameter int SW    = DEF_SW,
  parameter int IW    = DEF_IW,
  parameter int K     = DEF_K,
  parameter int CNT_W = 16
);

  localparam int RW = rule_idx_w(K);

  logic [IW-1:0]    x_in;
  logic             x_valid;
  logic             cfg_we;
  logic [SW-1:0]    cfg_state;
  logic [RW-1:0]    cfg_rule;
  logic             cfg_en;
  logic [IW-1:0]    cfg_val;
  logic [IW-1:0]    cfg_mask;
  logic [SW-1:0]    cfg_next;
  logic [SW-1:0]    y_out;
  logic             hit;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output x_in, x_valid, cfg_we, cfg_state, cfg_rule, cfg_en, cfg_val, cfg_mask, cfg_next,
    input  y_out, hit, step_cnt
  );

  modport slave (
    input  x_in, x_valid, cfg_we, cfg_state, cfg_rule, cfg_en, cfg_val, cfg_mask, cfg_next,
    output y_out, hit, step_cnt
  );

endinterface

// File: rtl/fsm_table_engine_rule_match.sv
// K-way masked compare of one state's rules against the input symbol;
// the lowest-numbered enabled matching rule supplies the next state.
module fsm_rule_match #(
  parameter int SW = 4,
  parameter int IW = 4,
  parameter int K  = 6
) (
  input  logic [K-1:0]         en,
  input  logic [K-1:0][IW-1:0] val,
  input  logic [K-1:0][IW-1:0] mask,
  input  logic [K-1:0][SW-1:0] next,
  input  logic [IW-1:0]        x_in,
  output logic                 match,
  output logic [SW-1:0]        next_state
);

  // Scanning from the highest index down lets the lowest matching rule win.
  always_comb begin
    match      = 1'b0;
    next_state = '0;
    for (int r = K - 1; r >= 0; r--) begin
      if (en[r] && (((x_in ^ val[r]) & mask[r]) == '0)) begin
        match      = 1'b1;
        next_state = next[r];
      end
    end
  end

endmodule

// File: rtl/fsm_table_engine.sv
// Programmable Moore FSM whose transitions live in a writable rule table.
// Define FSM_STEP_CNT_EN to build the saturating transition counter.
module fsm_table_engine
  import fsm_tbl_pkg::*;
#(
  parameter int SW        = DEF_SW,
  parameter int IW        = DEF_IW,
  parameter int K         = DEF_K,
  parameter int RST_STATE = 0,
  parameter int CNT_W     = 16
) (
  input  logic     TCK,
  input  logic     RESET,
  fsm_tbl_if.slave bus
);

  localparam int NS = 1 << SW;

  logic [NS-1:0][K-1:0] en_tbl;
  logic [IW-1:0]        val_tbl  [NS][K];
  logic [IW-1:0]        mask_tbl [NS][K];
  logic [SW-1:0]        next_tbl [NS][K];

  logic [K-1:0]         cur_en;
  logic [K-1:0][IW-1:0] cur_val;
  logic [K-1:0][IW-1:0] cur_mask;
  logic [K-1:0][SW-1:0] cur_next;

  logic [SW-1:0] state;
  logic          hit_r;
  logic          match;
  logic [SW-1:0] match_next;
  logic          wr_ok;

  assign wr_ok = bus.cfg_we && (32'(bus.cfg_rule) < 32'(K));

  // Only the enable bits need clearing; the other fields are ignored while disabled.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      en_tbl <= '0;
    end else if (wr_ok) begin
      en_tbl[bus.cfg_state][bus.cfg_rule] <= bus.cfg_en;
    end
  end

  always_ff @(posedge TCK) begin
    if (!RESET && wr_ok) begin
      val_tbl[bus.cfg_state][bus.cfg_rule]  <= bus.cfg_val;
      mask_tbl[bus.cfg_state][bus.cfg_rule] <= bus.cfg_mask;
      next_tbl[bus.cfg_state][bus.cfg_rule] <= bus.cfg_next;
    end
  end

  always_comb begin
    cur_en   = '0;
    cur_val  = '0;
    cur_mask = '0;
    cur_next = '0;
    for (int r = 0; r < K; r++) begin
      cur_en[r]   = en_tbl[state][r];
      cur_val[r]  = val_tbl[state][r];
      cur_mask[r] = mask_tbl[state][r];
      cur_next[r] = next_tbl[state][r];
    end
  end

  fsm_rule_match #(
    .SW(SW),
    .IW(IW),
    .K (K)
  ) u_match (
    .en        (cur_en),
    .val       (cur_val),
    .mask      (cur_mask),
    .next      (cur_next),
    .x_in      (bus.x_in),
    .match     (match),
    .next_state(match_next)
  );

  // Step reads the table as it stood before this edge's write, so collisions see old rules.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      state <= SW'(RST_STATE);
      hit_r <= 1'b0;
    end else if (bus.x_valid && match) begin
      state <= match_next;
      hit_r <= 1'b1;
    end else begin
      hit_r <= 1'b0;
    end
  end

  assign bus.y_out = state;
  assign bus.hit   = hit_r;

`ifdef FSM_STEP_CNT_EN
  logic [CNT_W-1:0] step_cnt_r;

  always_ff @(posedge TCK) begin
    if (RESET) begin
      step_cnt_r <= '0;
    end else if (hit_r && (step_cnt_r != {CNT_W{1'b1}})) begin
      step_cnt_r <= step_cnt_r + 1'b1;
    end
  end

  assign bus.step_cnt = step_cnt_r;
`else
  assign bus.step_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fsm_table_engine.sv
// Directed self-checking bench for fsm_table_engine with hand-computed expectations.
module tb_fsm_table_engine;
  import fsm_tbl_pkg::*;

  localparam int SW    = 4;
  localparam int IW    = 4;
  localparam int K     = 6;
  localparam int CNT_W = 2;

  logic TCK;
  logic RESET;
  int   total_checks;
  int   bad_checks;

  fsm_tbl_if #(.SW(SW), .IW(IW), .K(K), .CNT_W(CNT_W)) bus ();

  fsm_table_engine #(
    .SW       (SW),
    .IW       (IW),
    .K        (K),
    .RST_STATE(0),
    .CNT_W    (CNT_W)
  ) dut (
    .TCK  (TCK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic setRule(input logic [3:0] st, input logic [2:0] r, input rule_t rule);
    bus.cfg_state = st;
    bus.cfg_rule  = r;
    bus.cfg_en    = rule.en;
    bus.cfg_val   = rule.val;
    bus.cfg_mask  = rule.mask;
    bus.cfg_next  = rule.next;
  endtask

  task automatic writeRule(input logic [3:0] st, input logic [2:0] r, input rule_t rule);
    setRule(st, r, rule);
    bus.cfg_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] x, input logic valid);
    bus.x_in    = x;
    bus.x_valid = valid;
    tick();
    bus.x_valid = 1'b0;
  endtask

  logic [1:0] cnt_exp [5];

  initial begin
    total_checks  = 0;
    bad_checks    = 0;
    RESET         = 1'b1;
    bus.x_in      = '0;
    bus.x_valid   = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_state = '0;
    bus.cfg_rule  = '0;
    bus.cfg_en    = 1'b0;
    bus.cfg_val   = '0;
    bus.cfg_mask  = '0;
    bus.cfg_next  = '0;
`ifdef FSM_STEP_CNT_EN
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    cnt_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    tick();
    doReset();
    checkOutput("reset_y", 32'(bus.y_out), 32'h0);
    checkOutput("reset_hit", 32'(bus.hit), 32'h0);
    checkOutput("reset_cnt", 32'(bus.step_cnt), 32'h0);

    // Basic step and hold on idle
    writeRule(4'd0, 3'd0, '{1'b1, 4'b0010, 4'b1111, 4'b0001});
    applyStimulus(4'b0010, 1'b1);
    checkOutput("basic_y", 32'(bus.y_out), 32'h1);
    checkOutput("basic_hit", 32'(bus.hit), 32'h1);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("idle_hit", 32'(bus.hit), 32'h0);
    checkOutput("idle_y", 32'(bus.y_out), 32'h1);

    // Masking
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b1000, 4'b1101, 4'b0110});
    applyStimulus(4'b1010, 1'b1);
    checkOutput("mask_dontcare_y", 32'(bus.y_out), 32'h6);
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b1000, 4'b1101, 4'b0110});
    applyStimulus(4'b1000, 1'b1);
    checkOutput("mask_exact_y", 32'(bus.y_out), 32'h6);
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b1000, 4'b1101, 4'b0110});
    applyStimulus(4'b1001, 1'b1);
    checkOutput("mask_miss_y", 32'(bus.y_out), 32'h0);
    checkOutput("mask_miss_hit", 32'(bus.hit), 32'h0);

    // Priority: wildcard rule0 beats exact rule1
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b0000, 4'b0000, 4'b0011});
    writeRule(4'd0, 3'd1, '{1'b1, 4'b0101, 4'b1111, 4'b1100});
    applyStimulus(4'b0101, 1'b1);
    checkOutput("prio_y", 32'(bus.y_out), 32'h3);
    doReset();
    writeRule(4'd0, 3'd0, '{1'b0, 4'b0000, 4'b0000, 4'b0011});
    writeRule(4'd0, 3'd1, '{1'b1, 4'b0101, 4'b1111, 4'b1100});
    applyStimulus(4'b0101, 1'b1);
    checkOutput("prio_disabled_y", 32'(bus.y_out), 32'hc);

    // Unprogrammed table never hits
    doReset();
    applyStimulus(4'b1111, 1'b1);
    checkOutput("unprog_y", 32'(bus.y_out), 32'h0);
    checkOutput("unprog_hit", 32'(bus.hit), 32'h0);

    // Out-of-range rule index is dropped; last legal index works
    writeRule(4'd0, 3'd7, '{1'b1, 4'b0000, 4'b0000, 4'b0101});
    writeRule(4'd0, 3'd6, '{1'b1, 4'b0000, 4'b0000, 4'b0101});
    applyStimulus(4'b0000, 1'b1);
    checkOutput("oor_y", 32'(bus.y_out), 32'h0);
    checkOutput("oor_hit", 32'(bus.hit), 32'h0);
    writeRule(4'd0, 3'd5, '{1'b1, 4'b0000, 4'b0000, 4'b1001});
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rule5_y", 32'(bus.y_out), 32'h9);

    // Write and step in the same cycle: the step uses the old rule
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b0010, 4'b1111, 4'b0001});
    setRule(4'd0, 3'd0, '{1'b1, 4'b0010, 4'b1111, 4'b0111});
    bus.cfg_we = 1'b1;
    applyStimulus(4'b0010, 1'b1);
    bus.cfg_we = 1'b0;
    checkOutput("collide_y", 32'(bus.y_out), 32'h1);
    checkOutput("collide_hit", 32'(bus.hit), 32'h1);

    // Reset mid-operation together with a config write
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b0010, 4'b1111, 4'b0001});
    writeRule(4'd1, 3'd0, '{1'b1, 4'b0011, 4'b1111, 4'b0011});
    applyStimulus(4'b0010, 1'b1);
    checkOutput("walk1_y", 32'(bus.y_out), 32'h1);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("walk3_y", 32'(bus.y_out), 32'h3);
    setRule(4'd0, 3'd0, '{1'b1, 4'b1111, 4'b0000, 4'b1010});
    bus.cfg_we = 1'b1;
    doReset();
    bus.cfg_we = 1'b0;
    checkOutput("midrst_y", 32'(bus.y_out), 32'h0);
    checkOutput("midrst_hit", 32'(bus.hit), 32'h0);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("cleared_y", 32'(bus.y_out), 32'h0);
    checkOutput("cleared_hit", 32'(bus.hit), 32'h0);

    // Five self-loop hits drive the (optional) saturating counter
    doReset();
    writeRule(4'd0, 3'd0, '{1'b1, 4'b0000, 4'b0000, 4'b0000});
    bus.x_in    = 4'b0000;
    bus.x_valid = 1'b1;
    tick();
    checkOutput("selfloop_hit", 32'(bus.hit), 32'h1);
    checkOutput("selfloop_y", 32'(bus.y_out), 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.x_valid = 1'b0;
      tick();
      checkOutput($sformatf("cnt_%0d", i), 32'(bus.step_cnt), 32'(cnt_exp[i]));
    end
    doReset();
    checkOutput("cnt_after_reset", 32'(bus.step_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
